// File: rtl/genome_axi_mem_responder.sv
// AXI4 INCR-burst responder backed by a word-addressed on-chip memory with byte strobes; reads
// return the first beat 1 cycle after AR and then 1 beat/cycle, and stall under rready=0. Optional checker: GENOME_MEM_PROTOCOL_CHECK_EN.
module genome_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_WORDS  = 256
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            proto_err
);

  localparam int NB  = C_S_AXI_DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = $clog2(C_MEM_DEPTH_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH_WORDS];

  wstate_t       wstate;
  logic [IW-1:0] wptr;
  logic [7:0]    wlen;
  logic [7:0]    wcnt;
  logic          w_fire;

  rstate_t       rstate;
  logic [IW-1:0] rptr;
  logic [7:0]    rlen;
  logic [7:0]    rcnt;
  logic [IW-1:0] ar_idx;

  assign w_fire = s_axi_wvalid & s_axi_wready;
  assign ar_idx = s_axi_araddr[OFS +: IW];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wstate        <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      wptr          <= '0;
      wlen          <= '0;
      wcnt          <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            wptr          <= s_axi_awaddr[OFS +: IW];
            wlen          <= s_axi_awlen;
            wcnt          <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          // Burst length comes from awlen only; wlast never ends the burst.
          if (w_fire) begin
            wptr <= wptr + IW'(1);
            wcnt <= wcnt + 8'd1;
            if (wcnt == wlen) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              wstate       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Not reset: contents survive reset and are never initialised.
  always_ff @(posedge ap_clk) begin
    if (w_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[wptr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Nonblocking read of mem gives pre-write data when a write hits the same word that edge.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rstate        <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      rptr          <= '0;
      rlen          <= '0;
      rcnt          <= '0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rdata   <= mem[ar_idx];
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            rlen          <= s_axi_arlen;
            rcnt          <= '0;
            rptr          <= ar_idx + IW'(1);
            s_axi_arready <= 1'b0;
            rstate        <= R_BURST;
          end
        end
        R_BURST: begin
          if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              rstate        <= R_IDLE;
            end else begin
              s_axi_rdata <= mem[rptr];
              rptr        <= rptr + IW'(1);
              rcnt        <= rcnt + 8'd1;
              s_axi_rlast <= ((rcnt + 8'd1) == rlen);
            end
          end
        end
      endcase
    end
  end

`ifdef GENOME_MEM_PROTOCOL_CHECK_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      proto_err <= 1'b0;
    end else if ((wstate == W_IDLE && s_axi_wvalid) ||
                 (w_fire && (s_axi_wlast != (wcnt == wlen)))) begin
      proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

  // Address bits outside the word index (and wlast without the checker) are don't-care.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast};

endmodule

// File: doc/genome_axi_mem_responder.md
# genome_axi_mem_responder

AXI4 responder (slave) with on-chip memory, acting as the far end of the `m00`/`m01` master ports used by the genomics kernels' read and write engines. It accepts INCR bursts on independent read and write channels and stores data in a word-addressed array with byte strobes. It backs kernel-level simulation and on-chip scratch use, and answers exactly the AXI subset the kernel masters drive: no id, size, burst-type or resp signals.

## Interface
- `C_S_AXI_ADDR_WIDTH`, 64, address width.
- `C_S_AXI_DATA_WIDTH`, 512, data width; power of two, at least 32.
- `C_MEM_DEPTH_WORDS`, 256, memory depth in data words; power of two.
- `ap_clk  in  1  sole clock; all logic rising-edge.`
- `ap_rst_n  in  1  reset; asynchronous assert, active-low, released synchronously by the system.`
- `s_axi_awvalid in 1 / s_axi_awready out 1 / s_axi_awaddr in ADDR / s_axi_awlen in 8`: write address channel.
- `s_axi_wvalid in 1 / s_axi_wready out 1 / s_axi_wdata in DATA / s_axi_wstrb in DATA/8 / s_axi_wlast in 1`: write data channel.
- `s_axi_bvalid out 1 / s_axi_bready in 1`: write response channel.
- `s_axi_arvalid in 1 / s_axi_arready out 1 / s_axi_araddr in ADDR / s_axi_arlen in 8`: read address channel.
- `s_axi_rvalid out 1 / s_axi_rready in 1 / s_axi_rdata out DATA / s_axi_rlast out 1`: read data channel.
- `proto_err  out  1`: sticky protocol-error flag (see Configuration).

## Operation
- Word index is `addr[OFS +: log2(C_MEM_DEPTH_WORDS)]`, where `OFS = log2(DATA/8)`. Unaligned low bits are ignored.
- Beat k of a burst accesses word `(index + k) mod C_MEM_DEPTH_WORDS`; wraps silently. Burst length is `len + 1` beats, from 1 to 256.
- Write FSM:
  - W_IDLE: `awready=1`. On AW handshake, latch index and len; clear the beat counter; go to W_DATA.
  - W_DATA: `wready=1`. Each W handshake writes the bytes whose `wstrb` bit is set and increments the counter. The beat with counter == len goes to W_RESP.
  - W_RESP: `bvalid=1`, held until `bready`, then W_IDLE.
- Read FSM:
  - R_IDLE: `arready=1`. On AR handshake, load `rdata <= mem[index]`, set `rvalid=1`, set `rlast = (len==0)`, and go to R_BURST.
  - R_BURST: `rdata`, `rvalid` and `rlast` stay stable while `rready=0`.
  - On an R handshake with beats remaining, load the next word and update `rlast`. On the handshake with `rlast=1`, drop `rvalid` and go to R_IDLE.
- Read and write FSMs are fully independent and may run concurrently.
- Same-cycle write and read-load of the same word: the read returns the pre-write contents. A later beat loaded after the write returns the new data.
- Burst length is taken from `awlen`. `wlast` does not terminate the burst; it is only checked under the Configuration macro.
- Memory contents are not initialised or cleared by reset.

## Timing
- Reset values: `awready=0`, `arready=0`, `wready=0`, `bvalid=0`, `rvalid=0`, `rlast=0`, `rdata=0`, `proto_err=0`. Both FSMs reset to IDLE.
- `awready` and `arready` rise on the first `ap_clk` edge after reset release.
- All outputs are registered; no combinational path from any input to any output.
- AR handshake at edge N: first beat has `rvalid=1` from N+1. Sustained throughput is 1 beat/cycle while `rready=1`.
- AW handshake at edge N: `wready=1` from N+1. Last W handshake at M: `bvalid=1` from M+1. After B handshake at P: `awready=1` from P+1.
- Minimum write transaction is 3 cycles for 1 beat. Minimum read turnaround is 1 idle cycle between bursts, with `arready=1` in that cycle.
- Reset asserted mid-burst: all valids and readies drop asynchronously; the burst is abandoned. Memory words already written stay written.

## Configuration
- `GENOME_MEM_PROTOCOL_CHECK_EN` defined:
  - `proto_err` sets and stays at 1 until reset when a W beat has `wlast` != (counter == len).
  - It also sets when `wvalid=1` is seen in W_IDLE.
  - The flag fires and is otherwise ignored: data is still written per `awlen`.
- Not defined: checker logic is absent and `proto_err` is tied to 0.

## Test plan
- Single-beat write, addr 0x40, data 0xA5 pattern, `wstrb` all ones; then read of addr 0x40, len 0 → `bvalid` 1 cycle after W; `rdata`=0xA5 pattern with `rlast=1` one cycle after AR handshake.
- Write word 3 with all-ones data, then write word 3 with data 0 and `wstrb=0x1`; read word 3 → byte 0 = 0x00, all other bytes 0xFF.
- 16-beat read from index 250 (depth 256) with `rready` toggling 1/0 → 16 beats, words 250..255 then 0..9, data stable during stalls, `rlast` only on beat 16.
- Concurrent 256-beat write to index 0 and 256-beat read from index 128 → both complete, one `bvalid` pulse, read data matches the per-cycle ordering rule.
- Assert `ap_rst_n=0` at beat 5 of an 8-beat read → `rvalid` drops immediately. After release, `arready=1` one edge later and a new burst completes normally.
- With `GENOME_MEM_PROTOCOL_CHECK_EN`: 4-beat write with `wlast` on beat 2 → `proto_err=1` and stays 1; `bvalid` still follows beat 4. Without the macro, `proto_err` stays 0.
